// File: rtl/deser_pkg.sv
// Shared constants and a bit-ordering helper for the serial word deserializer.
package deser_pkg;

  localparam int unsigned DESER_WIDTH = 8;
  localparam int unsigned DESER_DEPTH = 4;

  // Word as presented on data_out when its bits are sent word[W-1] first.
  function automatic logic [DESER_WIDTH-1:0] bit_order(input logic [DESER_WIDTH-1:0] word,
                                                       input logic msb_first);
    logic [DESER_WIDTH-1:0] r_res;
    r_res = word;
    if (!msb_first) begin
      for (int unsigned i = 0; i < DESER_WIDTH; i++) begin
        r_res[i] = word[DESER_WIDTH-1-i];
      end
    end
    return r_res;
  endfunction

endpackage

// File: rtl/deserializer_fifo_sync_fifo.sv
// Level-tracked synchronous FIFO; head word is read combinationally and forced to 0 when empty.
module sync_fifo
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DESER_WIDTH,
  parameter int unsigned DEPTH = DESER_DEPTH
) (
  input  logic                     clock_100,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  always_comb begin
    o_full    = (r_level == LVL_W'(DEPTH));
    o_empty   = (r_level == '0);
    w_do_push = i_push && !o_full;
    w_do_pop  = i_pop && !o_empty;
    o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];
    o_level   = r_level;
  end

  always_ff @(posedge clock_100) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level moves only on unbalanced push/pop.
  always_ff @(posedge clock_100) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/deserializer_fifo.sv
// Serial-to-parallel converter: assembles WIDTH strobed bits into a word and queues it for a
// ready/ack consumer; only the word-completing bit stalls when the queue is full.
module deserializer_fifo
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH     = DESER_WIDTH,
  parameter int unsigned DEPTH     = DESER_DEPTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                   clock_100,
  input  logic                   reset,
  input  logic                   data_in,
  input  logic                   write_in,
  output logic                   in_ready,
  input  logic                   ack_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_last;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_next_word;

  // Readiness ignores ack_in on purpose so the stall decision never depends on the consumer.
  always_comb begin
    w_last   = (r_bit_cnt == LAST_BIT);
    in_ready = !(w_full && w_last);
    w_accept = write_in && in_ready;
    w_push   = w_accept && w_last;
    w_pop    = ack_in && !w_empty;
    if (MSB_FIRST) begin
      w_next_word = {r_shift[WIDTH-2:0], data_in};
    end else begin
      w_next_word = {data_in, r_shift[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock_100) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_shift   <= w_next_word;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
      if (write_in && !in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_100 (clock_100),
    .reset     (reset),
    .i_push    (w_push),
    .i_wdata   (w_next_word),
    .i_pop     (w_pop),
    .o_rdata   (data_out),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (level)
  );

  assign data_ready = !w_empty;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_deserializer_fifo.sv
// Directed bench for deserializer_fifo: MSB-first and LSB-first instances share stimulus and are
// checked against a word scoreboard plus a small bit-count/overflow model.
module tb_deserializer_fifo;
  import deser_pkg::*;

  localparam int unsigned W = DESER_WIDTH;
  localparam int unsigned D = DESER_DEPTH;

  logic                 clock_100 = 1'b0;
  logic                 reset     = 1'b1;
  logic                 data_in   = 1'b0;
  logic                 write_in  = 1'b0;
  logic                 ack_in    = 1'b0;

  logic                 in_ready_m, in_ready_l;
  logic [W-1:0]         data_out_m, data_out_l;
  logic                 data_ready_m, data_ready_l;
  logic [$clog2(D):0]   level_m, level_l;
  logic                 overflow_m, overflow_l;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [W-1:0] q_m [$];
  logic [W-1:0] q_l [$];
  int unsigned  m_cnt = 0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] m_pend = '0;

  always #5 clock_100 = ~clock_100;

  deserializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_dut_msb (
    .clock_100 (clock_100), .reset (reset), .data_in (data_in), .write_in (write_in),
    .in_ready (in_ready_m), .ack_in (ack_in), .data_out (data_out_m),
    .data_ready (data_ready_m), .level (level_m), .overflow (overflow_m)
  );

  deserializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clock_100 (clock_100), .reset (reset), .data_in (data_in), .write_in (write_in),
    .in_ready (in_ready_l), .ack_in (ack_in), .data_out (data_out_l),
    .data_ready (data_ready_l), .level (level_l), .overflow (overflow_l)
  );

  function automatic logic [W-1:0] reverse_bits(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = x[int'(W) - 1 - i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @%0t: observed=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " level_m"}, 32'(level_m), 32'(q_m.size()));
    check({tag, " level_l"}, 32'(level_l), 32'(q_l.size()));
    check({tag, " ready_m"}, 32'(data_ready_m), 32'(q_m.size() != 0));
    check({tag, " ovf_m"}, 32'(overflow_m), 32'(m_ovf));
    check({tag, " ovf_l"}, 32'(overflow_l), 32'(m_ovf));
    check({tag, " dout_m"}, 32'(data_out_m), 32'((q_m.size() != 0) ? q_m[0] : '0));
    check({tag, " dout_l"}, 32'(data_out_l), 32'((q_l.size() != 0) ? q_l[0] : '0));
  endtask

  // One clock: drive inputs, predict, tick, then compare post-edge state.
  task automatic cycle(input string tag, input logic w, input logic b, input logic a);
    logic exp_rdy, do_pop, do_push;
    write_in = w;
    data_in  = b;
    ack_in   = a;
    exp_rdy  = !(q_m.size() == int'(D) && m_cnt == W - 1);
    check({tag, " in_ready_m"}, 32'(in_ready_m), 32'(exp_rdy));
    check({tag, " in_ready_l"}, 32'(in_ready_l), 32'(exp_rdy));
    do_pop  = a && (q_m.size() != 0);
    do_push = w && exp_rdy && (m_cnt == W - 1);
    if (w && exp_rdy) m_cnt = (m_cnt == W - 1) ? 0 : m_cnt + 1;
    if (w && !exp_rdy) m_ovf = 1'b1;
    @(posedge clock_100);
    #1;
    write_in = 1'b0;
    ack_in   = 1'b0;
    data_in  = 1'b0;
    if (do_pop) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (do_push) begin
      q_m.push_back(m_pend);
      q_l.push_back(reverse_bits(m_pend));
    end
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    write_in = 1'b0;
    ack_in = 1'b0;
    @(posedge clock_100);
    #1;
    reset = 1'b0;
    q_m.delete();
    q_l.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    check("rst in_ready", 32'(in_ready_m), 32'd1);
    check_outputs("rst");
  endtask

  // Sends the first n bits of word, word[W-1] first.
  task automatic send_bits(input string tag, input logic [W-1:0] word, input int n);
    m_pend = word;
    for (int i = 0; i < n; i++) cycle(tag, 1'b1, word[int'(W) - 1 - i], 1'b0);
  endtask

  initial begin
    do_reset();

    // T1/T2: 1,0,1,0,1,1,0,1 -> 0xAD (MSB first), 0xB5 (LSB first)
    send_bits("T1", 8'hAD, 8);
    check("T1 dout_msb", 32'(data_out_m), 32'h0000_00AD);
    check("T2 dout_lsb", 32'(data_out_l), 32'h0000_00B5);
    check("T1 data_ready", 32'(data_ready_m), 32'd1);
    cycle("T1 ack", 1'b0, 1'b0, 1'b1);
    check("T1 empty", 32'(data_ready_m), 32'd0);

    // T3: fill, stall on completing bit, overflow, then drain
    send_bits("T3 w11", 8'h11, 8);
    send_bits("T3 w22", 8'h22, 8);
    send_bits("T3 w33", 8'h33, 8);
    send_bits("T3 w44", 8'h44, 8);
    check("T3 level4", 32'(level_m), 32'd4);
    send_bits("T3 w55p", 8'h55, 7);
    check("T3 stall", 32'(in_ready_m), 32'd0);
    cycle("T3 drop", 1'b1, 1'b1, 1'b0);
    check("T3 ovf", 32'(overflow_m), 32'd1);
    check("T3 level_hold", 32'(level_m), 32'd4);
    cycle("T3 pop", 1'b0, 1'b0, 1'b1);
    check("T3 head22", 32'(data_out_m), 32'h0000_0022);
    check("T3 ready_back", 32'(in_ready_m), 32'd1);
    cycle("T3 last", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("T3 drain", 1'b0, 1'b0, 1'b1);
    check("T3 drained", 32'(level_m), 32'd0);

    // T4: push and pop on the same edge
    do_reset();
    send_bits("T4 wA0", 8'hA0, 8);
    send_bits("T4 w0Fp", 8'h0F, 7);
    cycle("T4 both", 1'b1, 1'b1, 1'b1);
    check("T4 level1", 32'(level_m), 32'd1);
    check("T4 head0F", 32'(data_out_m), 32'h0000_000F);
    cycle("T4 pop", 1'b0, 1'b0, 1'b1);

    // T5: reset mid-word discards partial bits
    send_bits("T5 part", 8'hFF, 3);
    do_reset();
    send_bits("T5 w3C", 8'h3C, 8);
    check("T5 one_word", 32'(level_m), 32'd1);
    check("T5 head3C", 32'(data_out_m), 32'h0000_003C);
    check("T5 no_ovf", 32'(overflow_m), 32'd0);
    cycle("T5 pop", 1'b0, 1'b0, 1'b1);

    // T6: ack while empty is ignored
    cycle("T6 ack_empty", 1'b0, 1'b0, 1'b1);
    cycle("T6 ack_empty2", 1'b0, 1'b0, 1'b1);
    check("T6 dout0", 32'(data_out_m), 32'd0);
    send_bits("T6 wAD", 8'hAD, 8);
    check("T6 headAD", 32'(data_out_m), 32'h0000_00AD);
    cycle("T6 pop", 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
